codemem_port_arbiter: RTL and testbench
=======================================

Name: codemem_port_arbiter

Overview:
- Owns both ports of the 64x16 code memory (single write port, asynchronous read port).
- Shares the read port between instruction fetch and data loads (LOADF).
- Shares the write port between CPU data stores (STOREF) and a boot-time program loader that streams bytes in.
- Sits between the CPU core and the code memory. While a program load is running, the CPU is held off.

Parameters:
- AW, 6, address width; memory depth is 2**AW.
- DW, 16, word width; must be 2x the loader byte width.
- STARVE_MAX, 2, number of consecutive denied fetch cycles after which fetch wins the read port (range 1..7).
- LOAD_WORDS, 64, number of words written per load session, starting at address 0 (range 1..2**AW).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  start a load session; sampled only in IDLE
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte; high byte first, then low byte
- ld_ready  out  1  loader byte accepted when ld_valid & ld_ready
- load_busy  out  1  high in LOAD and DONE; CPU must stall
- load_done  out  1  one-cycle pulse at the end of a session
- if_req  in  1  fetch read request
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rdata  out  DW  fetch data, registered
- if_rvalid  out  1  if_rdata valid (one cycle after if_gnt)
- dr_req  in  1  data read request
- dr_addr  in  AW  data read address
- dr_gnt  out  1  data read granted this cycle
- dr_rdata  out  DW  data read data, registered
- dr_rvalid  out  1  dr_rdata valid (one cycle after dr_gnt)
- dw_req  in  1  data write request
- dw_addr  in  AW  data write address
- dw_data  in  DW  data write data
- dw_gnt  out  1  data write accepted this cycle
- mem_readselect  out  AW  to memory read address
- mem_outp  in  DW  from memory read data (combinational)
- mem_c1  out  1  to memory write enable
- mem_writeselect  out  AW  to memory write address
- mem_inp  out  DW  to memory write data

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE; word counter, byte phase, high-byte latch and starve counter clear to 0.
  - All registered outputs clear to 0: if_rdata, dr_rdata, if_rvalid, dr_rvalid, load_done.
  - Combinational outputs also read 0 while reset is asserted: grants, ld_ready, load_busy, mem_c1, and mem_* addresses and data.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD when load_start=1. load_start is ignored in LOAD and DONE.
  - LOAD -> DONE on the clock edge that writes word LOAD_WORDS-1.
  - DONE -> IDLE after exactly one cycle. load_done=1 only in DONE.
  - load_busy=1 in LOAD and DONE.
- LOAD state:
  - ld_ready=1 every cycle.
  - Phase 0: an accepted byte is latched as the high byte.
  - Phase 1: an accepted byte drives mem_c1=1 combinationally in that cycle, with mem_inp={hi,ld_byte} and mem_writeselect=counter. The counter increments at the edge.
  - ld_valid=0 stalls the session with no timeout.
  - In LOAD and DONE: if_gnt, dr_gnt and dw_gnt are 0, and CPU requests are held, not dropped.
  - ld_ready=0 outside LOAD.
- Write port (IDLE only): dw_gnt=dw_req, mem_c1=dw_req, mem_writeselect=dw_addr, mem_inp=dw_data. Writes complete in one cycle.
- Read port (IDLE only), combinational grant, at most one grant per cycle:
  - Default: data read wins over fetch.
  - If the starve counter equals STARVE_MAX and if_req=1, fetch wins.
  - Starve counter increments when if_req=1 and if_gnt=0. It clears when if_gnt=1 or if_req=0, and saturates at STARVE_MAX.
  - mem_readselect = the granted address, else if_addr.
  - On a grant, mem_outp is registered into the winner's rdata and its rvalid pulses for one cycle. The non-granted rdata holds its value.
- Read-before-write: a read and a write to the same address in the same cycle return the OLD contents.
- Reset mid-load: the session is abandoned. A latched high byte is discarded. The next session restarts at address 0. Words already written stay in memory.
- Counter width is AW+1 so that LOAD_WORDS=2**AW terminates without wrap.

Test Plan:
- Reset: hold reset=0 with all requests high -> all grants, mem_c1, ld_ready, load_busy and rvalids read 0. On release, state is IDLE.
- Full load: pulse load_start, then stream 128 bytes with byte n = n -> 64 writes with word k = {2k,2k+1}, so word 1 = 0x0203 and word 63 = 0x7E7F. load_done is high for exactly one cycle after the last write; load_busy falls the following cycle.
- Read contention (STARVE_MAX=2): hold if_req=dr_req=1 for 6 cycles -> grant sequence dr,dr,if,dr,dr,if. Each rvalid follows its grant by one cycle with the correct data.
- Same-address collision: in IDLE, dw_req to address 5 with data 0xBEEF while dr_req reads address 5 (old value 0x1234) -> dr_rdata=0x1234. A read one cycle later returns 0xBEEF.
- CPU blocked during load: dw_req, dr_req and if_req asserted in LOAD -> all grants 0 and mem_c1 is driven only by loader low bytes. Requests are granted in the first IDLE cycle after DONE.
- Reset mid-load: assert reset after 3 accepted bytes, then restart the load with 0xAA,0xBB -> address 0 = 0xAABB and address 1 is written only by the new stream.

Source files
------------

// File: rtl/codemem_port_arbiter_if.sv
// rtl/codemem_port_arbiter_if.sv - bus bundle between CPU, program loader, arbiter and code memory
// Ports (slave = arbiter view):
//   loader : load_start, ld_valid, ld_byte in; ld_ready, load_busy, load_done out
//   fetch  : if_req, if_addr in; if_gnt, if_rdata, if_rvalid out
//   dread  : dr_req, dr_addr in; dr_gnt, dr_rdata, dr_rvalid out
//   dwrite : dw_req, dw_addr, dw_data in; dw_gnt out
//   memory : mem_outp in; mem_readselect, mem_c1, mem_writeselect, mem_inp out
interface codemem_port_arbiter_if #(
   parameter int AW = 6,
   parameter int DW = 16
);
   logic              load_start;
   logic              ld_valid;
   logic [DW/2-1:0]   ld_byte;
   logic              ld_ready;
   logic              load_busy;
   logic              load_done;
   logic              if_req;
   logic [AW-1:0]     if_addr;
   logic              if_gnt;
   logic [DW-1:0]     if_rdata;
   logic              if_rvalid;
   logic              dr_req;
   logic [AW-1:0]     dr_addr;
   logic              dr_gnt;
   logic [DW-1:0]     dr_rdata;
   logic              dr_rvalid;
   logic              dw_req;
   logic [AW-1:0]     dw_addr;
   logic [DW-1:0]     dw_data;
   logic              dw_gnt;
   logic [AW-1:0]     mem_readselect;
   logic [DW-1:0]     mem_outp;
   logic              mem_c1;
   logic [AW-1:0]     mem_writeselect;
   logic [DW-1:0]     mem_inp;

   modport slave (
      input  load_start, ld_valid, ld_byte, if_req, if_addr, dr_req, dr_addr,
             dw_req, dw_addr, dw_data, mem_outp,
      output ld_ready, load_busy, load_done, if_gnt, if_rdata, if_rvalid,
             dr_gnt, dr_rdata, dr_rvalid, dw_gnt, mem_readselect, mem_c1,
             mem_writeselect, mem_inp
   );

   modport master (
      output load_start, ld_valid, ld_byte, if_req, if_addr, dr_req, dr_addr,
             dw_req, dw_addr, dw_data, mem_outp,
      input  ld_ready, load_busy, load_done, if_gnt, if_rdata, if_rvalid,
             dr_gnt, dr_rdata, dr_rvalid, dw_gnt, mem_readselect, mem_c1,
             mem_writeselect, mem_inp
   );
endinterface

// File: rtl/codemem_port_arbiter.sv
// rtl/codemem_port_arbiter.sv - code memory port arbiter with boot-time program loader
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : codemem_port_arbiter_if.slave (loader, fetch, data read/write, memory ports)
module codemem_port_arbiter #(
   parameter int AW         = 6,
   parameter int DW         = 16,
   parameter int STARVE_MAX = 2,
   parameter int LOAD_WORDS = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   codemem_port_arbiter_if.slave  bus
);
   localparam int BW = DW / 2;
   // Counter is AW+1 wide so a full-depth session ends without wrapping to 0.
   localparam logic [AW:0] LAST = (AW+1)'(LOAD_WORDS - 1);
   localparam logic [2:0]  SMAX = 3'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t          state, state_nxt;
   logic [AW:0]     cnt;
   logic            phase;
   logic [BW-1:0]   hi;
   logic [2:0]      starve;

   logic            if_g, dr_g, dw_g, ld_rdy, busy, c1;
   logic [AW-1:0]   rsel, wsel;
   logic [DW-1:0]   winp;
   logic            fetch_wins;

   always_comb begin
      state_nxt  = state;
      if_g       = 1'b0;
      dr_g       = 1'b0;
      dw_g       = 1'b0;
      ld_rdy     = 1'b0;
      busy       = 1'b0;
      c1         = 1'b0;
      rsel       = '0;
      wsel       = '0;
      winp       = '0;
      fetch_wins = bus.if_req && (starve == SMAX);
      // Every combinational output is forced low while reset is asserted.
      if (reset) begin
         rsel = bus.if_addr;
         case (state)
            IDLE: begin
               if (bus.load_start) state_nxt = LOAD;
               dr_g = bus.dr_req && !fetch_wins;
               if_g = bus.if_req && (fetch_wins || !bus.dr_req);
               if (dr_g) rsel = bus.dr_addr;
               dw_g = bus.dw_req;
               c1   = bus.dw_req;
               wsel = bus.dw_addr;
               winp = bus.dw_data;
            end
            LOAD: begin
               busy   = 1'b1;
               ld_rdy = 1'b1;
               wsel   = cnt[AW-1:0];
               winp   = {hi, bus.ld_byte};
               // A word is written only when its low byte arrives.
               c1     = bus.ld_valid && phase;
               if (bus.ld_valid && phase && cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
               busy      = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.if_gnt          = if_g;
   assign bus.dr_gnt          = dr_g;
   assign bus.dw_gnt          = dw_g;
   assign bus.ld_ready        = ld_rdy;
   assign bus.load_busy       = busy;
   assign bus.mem_c1          = c1;
   assign bus.mem_readselect  = rsel;
   assign bus.mem_writeselect = wsel;
   assign bus.mem_inp         = winp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         phase         <= 1'b0;
         hi            <= '0;
         starve        <= '0;
         bus.if_rdata  <= '0;
         bus.dr_rdata  <= '0;
         bus.if_rvalid <= 1'b0;
         bus.dr_rvalid <= 1'b0;
         bus.load_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.load_done <= (state_nxt == DONE);
         bus.if_rvalid <= if_g;
         bus.dr_rvalid <= dr_g;
         if (if_g) bus.if_rdata <= bus.mem_outp;
         if (dr_g) bus.dr_rdata <= bus.mem_outp;
         // Denied fetch cycles count up (also while held off by a load) and saturate.
         if (bus.if_req && !if_g)
            starve <= (starve == SMAX) ? SMAX : starve + 3'd1;
         else
            starve <= '0;
         if (state == LOAD) begin
            if (bus.ld_valid) begin
               phase <= ~phase;
               if (!phase) hi <= bus.ld_byte;
               else        cnt <= cnt + 1'b1;
            end
         end else begin
            cnt   <= '0;
            phase <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_codemem_port_arbiter.sv
// tb/tb_codemem_port_arbiter.sv - directed self-checking bench for codemem_port_arbiter
module tb_codemem_port_arbiter;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   logic [15:0] mem [0:63];

   codemem_port_arbiter_if #(.AW(6), .DW(16)) bus ();

   codemem_port_arbiter #(
      .AW(6), .DW(16), .STARVE_MAX(2), .LOAD_WORDS(64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Code memory model: asynchronous read, synchronous write.
   assign bus.mem_outp = mem[bus.mem_readselect];
   always @(posedge clk) if (bus.mem_c1) mem[bus.mem_writeselect] <= bus.mem_inp;

   task automatic idle_inputs();
      bus.load_start = 0; bus.ld_valid = 0; bus.ld_byte = '0;
      bus.if_req = 0; bus.if_addr = '0; bus.dr_req = 0; bus.dr_addr = '0;
      bus.dw_req = 0; bus.dw_addr = '0; bus.dw_data = '0;
   endtask

   task automatic rd(input logic [5:0] a, output logic [15:0] d, output logic v);
      @(negedge clk);
      bus.dr_req = 1; bus.dr_addr = a;
      @(posedge clk); #1;
      d = bus.dr_rdata; v = bus.dr_rvalid;
      bus.dr_req = 0;
   endtask

   task automatic start_load();
      @(negedge clk);
      bus.load_start = 1;
      @(negedge clk);
      bus.load_start = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      if ($time != 0) begin end
      bus.ld_valid = 1; bus.ld_byte = b;
   endtask

   task automatic test_reset();
      reset = 0;
      idle_inputs();
      bus.if_req = 1; bus.dr_req = 1; bus.dw_req = 1; bus.load_start = 1;
      bus.ld_valid = 1; bus.dw_addr = 6'd7; bus.dr_addr = 6'd9;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus.if_gnt, bus.dr_gnt, bus.dw_gnt} !== 3'b000) begin
         errors++; $display("FAIL reset_grants got %b expected 000", {bus.if_gnt, bus.dr_gnt, bus.dw_gnt});
      end
      checks++;
      if ({bus.mem_c1, bus.ld_ready, bus.load_busy} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl got %b expected 000", {bus.mem_c1, bus.ld_ready, bus.load_busy});
      end
      checks++;
      if ({bus.if_rvalid, bus.dr_rvalid, bus.load_done} !== 3'b000) begin
         errors++; $display("FAIL reset_regs got %b expected 000", {bus.if_rvalid, bus.dr_rvalid, bus.load_done});
      end
      checks++;
      if ({bus.mem_readselect, bus.mem_writeselect, bus.mem_inp} !== 28'd0) begin
         errors++; $display("FAIL reset_mem_bus got %h expected 0", {bus.mem_readselect, bus.mem_writeselect, bus.mem_inp});
      end
      @(negedge clk);
      idle_inputs();
      reset = 1;
      #1;
      checks++;
      if ({bus.load_busy, bus.ld_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_release_idle got %b expected 00", {bus.load_busy, bus.ld_ready});
      end
   endtask

   task automatic test_full_load();
      logic [15:0] d;
      logic        v;
      start_load();
      for (int n = 0; n < 128; n++) begin
         if (n != 0) @(negedge clk);
         send_byte(8'(n));
         #1;
         checks++;
         if (bus.mem_c1 !== n[0] || bus.ld_ready !== 1'b1 || bus.load_busy !== 1'b1) begin
            errors++; $display("FAIL load_ctrl byte %0d got c1=%b rdy=%b busy=%b expected c1=%b rdy=1 busy=1",
                               n, bus.mem_c1, bus.ld_ready, bus.load_busy, n[0]);
         end
         if (n[0]) begin
            checks++;
            if (bus.mem_writeselect !== 6'(n / 2) || bus.mem_inp !== {8'(n - 1), 8'(n)}) begin
               errors++; $display("FAIL load_write byte %0d got addr=%0d data=%h expected addr=%0d data=%h",
                                  n, bus.mem_writeselect, bus.mem_inp, n / 2, {8'(n - 1), 8'(n)});
            end
         end
      end
      @(negedge clk);
      bus.ld_valid = 0;
      #1;
      checks++;
      if ({bus.load_done, bus.load_busy, bus.ld_ready} !== 3'b110) begin
         errors++; $display("FAIL load_done_cycle got %b expected 110", {bus.load_done, bus.load_busy, bus.ld_ready});
      end
      @(negedge clk); #1;
      checks++;
      if ({bus.load_done, bus.load_busy} !== 2'b00) begin
         errors++; $display("FAIL load_after_done got %b expected 00", {bus.load_done, bus.load_busy});
      end
      rd(6'd1, d, v);
      checks++;
      if (d !== 16'h0203 || v !== 1'b1) begin
         errors++; $display("FAIL load_word1 got %h v=%b expected 0203 v=1", d, v);
      end
      rd(6'd63, d, v);
      checks++;
      if (d !== 16'h7E7F || v !== 1'b1) begin
         errors++; $display("FAIL load_word63 got %h v=%b expected 7e7f v=1", d, v);
      end
   endtask

   task automatic test_contention();
      logic exp_if;
      @(negedge clk);
      bus.if_req = 1; bus.if_addr = 6'd1; bus.dr_req = 1; bus.dr_addr = 6'd63;
      for (int i = 0; i < 6; i++) begin
         if (i != 0) @(negedge clk);
         exp_if = (i % 3 == 2);
         #1;
         checks++;
         if ({bus.if_gnt, bus.dr_gnt} !== {exp_if, ~exp_if}) begin
            errors++; $display("FAIL contention_gnt cycle %0d got if=%b dr=%b expected if=%b dr=%b",
                               i, bus.if_gnt, bus.dr_gnt, exp_if, ~exp_if);
         end
         @(posedge clk); #1;
         checks++;
         if ({bus.if_rvalid, bus.dr_rvalid} !== {exp_if, ~exp_if} ||
             (exp_if ? bus.if_rdata !== 16'h0203 : bus.dr_rdata !== 16'h7E7F)) begin
            errors++; $display("FAIL contention_rdata cycle %0d got ifv=%b drv=%b if=%h dr=%h expected ifv=%b",
                               i, bus.if_rvalid, bus.dr_rvalid, bus.if_rdata, bus.dr_rdata, exp_if);
         end
      end
      bus.if_req = 0; bus.dr_req = 0;
   endtask

   task automatic test_collision();
      logic [15:0] d;
      logic        v;
      @(negedge clk);
      bus.dw_req = 1; bus.dw_addr = 6'd5; bus.dw_data = 16'h1234;
      #1;
      checks++;
      if ({bus.dw_gnt, bus.mem_c1} !== 2'b11 || bus.mem_writeselect !== 6'd5) begin
         errors++; $display("FAIL collision_prewrite got gnt=%b c1=%b addr=%0d expected 1 1 5",
                            bus.dw_gnt, bus.mem_c1, bus.mem_writeselect);
      end
      @(negedge clk);
      bus.dw_data = 16'hBEEF; bus.dr_req = 1; bus.dr_addr = 6'd5;
      #1;
      checks++;
      if ({bus.dw_gnt, bus.dr_gnt} !== 2'b11) begin
         errors++; $display("FAIL collision_gnts got %b expected 11", {bus.dw_gnt, bus.dr_gnt});
      end
      @(posedge clk); #1;
      bus.dw_req = 0; bus.dr_req = 0;
      checks++;
      if (bus.dr_rdata !== 16'h1234 || bus.dr_rvalid !== 1'b1) begin
         errors++; $display("FAIL collision_old got %h v=%b expected 1234 v=1", bus.dr_rdata, bus.dr_rvalid);
      end
      rd(6'd5, d, v);
      checks++;
      if (d !== 16'hBEEF) begin
         errors++; $display("FAIL collision_new got %h expected beef", d);
      end
   endtask

   task automatic test_blocked_during_load();
      logic [15:0] d;
      logic        v;
      int          bi;
      int          c;
      logic        send;
      start_load();
      bus.dw_req = 1; bus.dw_addr = 6'd10; bus.dw_data = 16'h5555;
      bus.dr_req = 1; bus.dr_addr = 6'd1; bus.if_req = 1; bus.if_addr = 6'd2;
      bi = 0; c = 0;
      while (bi < 128 && c < 400) begin
         if (c != 0) @(negedge clk);
         send = (c % 5 != 4);
         bus.ld_valid = send; bus.ld_byte = 8'(bi + 128);
         #1;
         checks++;
         if ({bus.if_gnt, bus.dr_gnt, bus.dw_gnt} !== 3'b000 || bus.mem_c1 !== (send && bi[0])) begin
            errors++; $display("FAIL blocked_cycle %0d got gnts=%b c1=%b expected gnts=000 c1=%b",
                               c, {bus.if_gnt, bus.dr_gnt, bus.dw_gnt}, bus.mem_c1, send && bi[0]);
         end
         if (send && bi[0]) begin
            checks++;
            if (bus.mem_writeselect !== 6'(bi / 2)) begin
               errors++; $display("FAIL blocked_waddr got %0d expected %0d", bus.mem_writeselect, bi / 2);
            end
         end
         if (send) bi++;
         c++;
      end
      checks++;
      if (bi != 128) begin
         errors++; $display("FAIL blocked_budget got %0d bytes expected 128", bi);
      end
      @(negedge clk);
      bus.ld_valid = 0;
      #1;
      checks++;
      if (bus.load_done !== 1'b1 || {bus.if_gnt, bus.dr_gnt, bus.dw_gnt} !== 3'b000) begin
         errors++; $display("FAIL blocked_done got done=%b gnts=%b expected 1 000",
                            bus.load_done, {bus.if_gnt, bus.dr_gnt, bus.dw_gnt});
      end
      @(negedge clk); #1;
      checks++;
      if (bus.dw_gnt !== 1'b1 || (bus.if_gnt ^ bus.dr_gnt) !== 1'b1 || bus.load_busy !== 1'b0) begin
         errors++; $display("FAIL blocked_first_idle got dw=%b if=%b dr=%b busy=%b expected dw=1 one read grant busy=0",
                            bus.dw_gnt, bus.if_gnt, bus.dr_gnt, bus.load_busy);
      end
      @(posedge clk); #1;
      idle_inputs();
      rd(6'd1, d, v);
      checks++;
      if (d !== 16'h8283) begin
         errors++; $display("FAIL blocked_word1 got %h expected 8283", d);
      end
      rd(6'd10, d, v);
      checks++;
      if (d !== 16'h5555) begin
         errors++; $display("FAIL blocked_word10 got %h expected 5555", d);
      end
   endtask

   task automatic test_reset_midload();
      logic [15:0] d;
      logic        v;
      start_load();
      send_byte(8'h11);
      @(negedge clk); send_byte(8'h22);
      @(negedge clk); send_byte(8'h33);
      @(negedge clk);
      bus.ld_valid = 0; reset = 0;
      #1;
      checks++;
      if ({bus.load_busy, bus.ld_ready, bus.mem_c1} !== 3'b000) begin
         errors++; $display("FAIL midload_reset got %b expected 000", {bus.load_busy, bus.ld_ready, bus.mem_c1});
      end
      @(negedge clk);
      reset = 1;
      start_load();
      send_byte(8'hAA);
      #1;
      checks++;
      if (bus.mem_c1 !== 1'b0) begin
         errors++; $display("FAIL midload_stale_hi got c1=%b expected 0", bus.mem_c1);
      end
      @(negedge clk); send_byte(8'hBB);
      #1;
      checks++;
      if (bus.mem_c1 !== 1'b1 || bus.mem_writeselect !== 6'd0 || bus.mem_inp !== 16'hAABB) begin
         errors++; $display("FAIL midload_first_word got c1=%b addr=%0d data=%h expected 1 0 aabb",
                            bus.mem_c1, bus.mem_writeselect, bus.mem_inp);
      end
      @(negedge clk); send_byte(8'hCC);
      @(negedge clk); send_byte(8'hDD);
      @(negedge clk);
      bus.ld_valid = 0; reset = 0;
      @(negedge clk);
      reset = 1;
      rd(6'd0, d, v);
      checks++;
      if (d !== 16'hAABB) begin
         errors++; $display("FAIL midload_word0 got %h expected aabb", d);
      end
      rd(6'd1, d, v);
      checks++;
      if (d !== 16'hCCDD) begin
         errors++; $display("FAIL midload_word1 got %h expected ccdd", d);
      end
      rd(6'd2, d, v);
      checks++;
      if (d !== 16'h8485) begin
         errors++; $display("FAIL midload_word2 got %h expected 8485", d);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_full_load();
      test_contention();
      test_collision();
      test_blocked_during_load();
      test_reset_midload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
